// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit.
//
// Multiplication uses one shift-add step per cycle. Division uses one
// restoring shift-subtract step per cycle. Both run on magnitudes, and the
// sign is fixed up at the end. Divide-by-zero and signed overflow are
// resolved straight away and never enter the iteration loop.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - request a new operation (only honoured in IDLE)
//   op     - RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b   - rs1 / rs2 operands
//   flush  - abort the current operation, return to IDLE
//   busy   - high while iterating
//   done   - one-cycle pulse when result is updated
//   result - last completed result, held until overwritten
//   stall  - EX-stage hold request to the hazard unit
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             stall
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic               bypass_q, bypass_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic               signed_a, signed_b, a_neg_in, b_neg_in;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in, bypass_val;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_val;

  // Operand decode at the point of acceptance, and the per-cycle datapath.
  always_comb begin
    signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg_in = signed_a & a[WIDTH-1];
    b_neg_in = signed_b & b[WIDTH-1];
    a_mag_in = a_neg_in ? -a : a;
    b_mag_in = b_neg_in ? -b : b;

    div_zero = (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    // Remainder ops have op[1] set; quotient ops do not.
    if (div_zero) bypass_val = op[1] ? a : '1;
    else          bypass_val = op[1] ? '0 : MIN_NEG;

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift right including the carry.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: upper half is the partial remainder, lower half
    // shifts the dividend out and the quotient bits in.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, b_mag_q};
    div_step  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo_fix  = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (op_q)
      OP_MUL:                         final_val = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   final_val = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:                final_val = quo_fix;
      OP_REM, OP_REMU:                final_val = rem_fix;
      default:                        final_val = '0;
    endcase
    if (bypass_q) final_val = acc_q[WIDTH-1:0];
  end

  // Next-state logic. Flush overrides every state and suppresses done.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    bypass_d = bypass_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          a_mag_d = a_mag_in;
          b_mag_d = b_mag_in;
          a_neg_d = a_neg_in;
          b_neg_d = b_neg_in;
          if (op[2] && (div_zero || div_ovf)) begin
            bypass_d = 1'b1;
            acc_d    = {{WIDTH{1'b0}}, bypass_val};
            cnt_d    = '0;
            state_d  = S_DONE;
          end else begin
            bypass_d = 1'b0;
            acc_d    = {{WIDTH{1'b0}}, op[2] ? a_mag_in : b_mag_in};
            cnt_d    = CW'(WIDTH-1);
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        result_d = final_val;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      bypass_q <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      bypass_q <= bypass_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == S_CALC);
  assign done   = done_q;
  assign result = result_q;
  // Reset gates the combinational start term so stall is low while in reset.
  assign stall  = ~rst & (((state_q == S_IDLE) & start & ~flush) | busy);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq (WIDTH=32).
// A behavioural model predicts each result and its completion cycle; a
// compare process checks done/result every cycle against it, and directed
// vectors carry hand-computed literal results and latencies.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        stall;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  logic        check_en    = 1'b0;
  logic        exp_pending = 1'b0;
  int          exp_done_cyc = 0;
  logic [31:0] exp_result  = '0;
  logic [31:0] held_result = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  muldiv_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference result from plain 64-bit arithmetic and the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] m_op, input logic [31:0] m_a,
                                        input logic [31:0] m_b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pv;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(m_a));
    sb  = longint'($signed(m_b));
    ua  = longint'({32'h0, m_a});
    ub  = longint'({32'h0, m_b});
    ovf = (m_a == 32'h8000_0000) && (m_b == 32'hFFFF_FFFF);
    r   = '0;
    p   = 0;
    case (m_op)
      3'd0: begin p = ua * ub; pv = p; r = pv[31:0];  end
      3'd1: begin p = sa * sb; pv = p; r = pv[63:32]; end
      3'd2: begin p = sa * ub; pv = p; r = pv[63:32]; end
      3'd3: begin p = ua * ub; pv = p; r = pv[63:32]; end
      3'd4: begin
        if (m_b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin p = sa / sb; pv = p; r = pv[31:0]; end
      end
      3'd5: r = (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
      3'd6: begin
        if (m_b == 0) r = m_a;
        else if (ovf) r = 32'h0;
        else begin p = sa % sb; pv = p; r = pv[31:0]; end
      end
      default: r = (m_b == 0) ? m_a : m_a % m_b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] m_op, input logic [31:0] m_a,
                                   input logic [31:0] m_b);
    logic ovf;
    ovf = ((m_op == 3'd4) || (m_op == 3'd6)) && (m_a == 32'h8000_0000) && (m_b == 32'hFFFF_FFFF);
    if (m_op[2] && ((m_b == 0) || ovf)) return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Called at a negedge: drives one request, returns just after the
  // accepting edge with the model's prediction armed.
  task automatic applyStimulus(input logic [2:0] s_op, input logic [31:0] s_a,
                               input logic [31:0] s_b, output int n0);
    start = 1'b1;
    op    = s_op;
    a     = s_a;
    b     = s_b;
    @(posedge clk);
    #1;
    start        = 1'b0;
    n0           = cyc;
    exp_result   = model(s_op, s_a, s_b);
    exp_done_cyc = n0 + model_lat(s_op, s_a, s_b);
    exp_pending  = 1'b1;
  endtask

  // Waits (bounded) for done, counting cycles with stall high on the way.
  task automatic waitDone(output int done_cyc, output int stall_cnt);
    done_cyc  = -1;
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc = cyc;
        checkOutput("stall_on_done", {31'b0, stall}, 32'd0);
        return;
      end
      if (stall === 1'b1) stall_cnt++;
    end
    tests++;
    failed++;
    $display("[TB] FAIL done_timeout: got no done within 40 cycles, expected a done pulse");
  endtask

  // Every cycle: done must pulse exactly on the predicted cycle, and result
  // must hold its last value otherwise.
  always @(negedge clk) begin
    if (check_en) begin
      if (exp_pending && (cyc == exp_done_cyc)) begin
        checkOutput("cmp_done", {31'b0, done}, 32'd1);
        checkOutput("cmp_result", result, exp_result);
        held_result = exp_result;
        exp_pending = 1'b0;
      end else begin
        checkOutput("cmp_no_done", {31'b0, done}, 32'd0);
        checkOutput("cmp_held", result, held_result);
      end
    end
  end

  initial begin
    int n0, t1, t2, scnt;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[3]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'd100,        32'd0,         32'd100,       1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{3'd1, 32'h8000_0000,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[13] = '{3'd2, 32'd2,          32'h8000_0000, 32'h0000_0001, 33};
    vecs[14] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[15] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[16] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[17] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1};
    vecs[18] = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    vecs[19] = '{3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy",   {31'b0, busy},  32'd0);
    checkOutput("reset_done",   {31'b0, done},  32'd0);
    checkOutput("reset_stall",  {31'b0, stall}, 32'd0);
    checkOutput("reset_result", result,         32'd0);
    rst         = 1'b0;
    held_result = '0;
    check_en    = 1'b1;
    @(negedge clk);

    // Directed vectors: literal result, latency and stall profile.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, n0);
      waitDone(t1, scnt);
      checkOutput($sformatf("vec%0d_result", i), result, vecs[i].exp);
      checkOutput($sformatf("vec%0d_latency", i), 32'(t1 - n0), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d_stall_cycles", i), 32'(scnt), 32'(vecs[i].lat - 1));
    end

    // Flush beats start in IDLE.
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    #1;
    checkOutput("flush_prio_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_prio_busy", {31'b0, busy}, 32'd0);

    // Flush on the 10th CALC cycle: no done, result keeps 0xFFFFFFFF.
    applyStimulus(3'd0, 32'h1234, 32'h10, n0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush       = 1'b0;
    exp_pending = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy",   {31'b0, busy}, 32'd0);
    checkOutput("flush_done",   {31'b0, done}, 32'd0);
    checkOutput("flush_result", result,        32'hFFFF_FFFF);
    applyStimulus(3'd5, 32'd1000, 32'd10, n0);
    waitDone(t1, scnt);
    checkOutput("after_flush_result",  result,       32'd100);
    checkOutput("after_flush_latency", 32'(t1 - n0), 32'd33);

    // start held and operands changed during CALC are ignored.
    applyStimulus(3'd0, 32'h1000, 32'h1000, n0);
    repeat (20) begin
      @(negedge clk);
      start = 1'b1;
      op    = 3'd4;
      a     = $urandom;
      b     = $urandom;
    end
    start = 1'b0;
    waitDone(t1, scnt);
    checkOutput("hold_result",  result,       32'h0100_0000);
    checkOutput("hold_latency", 32'(t1 - n0), 32'd33);

    // Reset mid-CALC aborts everything, overriding a pending start.
    applyStimulus(3'd4, 32'd1000, 32'd3, n0);
    repeat (6) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    #1;
    checkOutput("rst_stall_override", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    exp_pending = 1'b0;
    held_result = '0;
    @(negedge clk);
    checkOutput("rst_busy",   {31'b0, busy},  32'd0);
    checkOutput("rst_done",   {31'b0, done},  32'd0);
    checkOutput("rst_stall",  {31'b0, stall}, 32'd0);
    checkOutput("rst_result", result,         32'd0);
    rst = 1'b0; start = 1'b0;
    applyStimulus(3'd5, 32'd100, 32'd7, n0);
    waitDone(t1, scnt);
    checkOutput("post_rst_result",  result,       32'd14);
    checkOutput("post_rst_latency", 32'(t1 - n0), 32'd33);

    // Back-to-back MULs: second start issued in the done cycle.
    applyStimulus(3'd0, 32'd3, 32'd5, n0);
    waitDone(t1, scnt);
    checkOutput("b2b_first_result", result, 32'd15);
    applyStimulus(3'd0, 32'h0000_FFFF, 32'h0001_0001, n0);
    waitDone(t2, scnt);
    checkOutput("b2b_second_result", result,       32'hFFFF_FFFF);
    checkOutput("b2b_spacing",       32'(t2 - t1), 32'd34);

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
